// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// The operand is split into NG = WIDTH/GROUP groups. Each pipeline stage resolves
// one group with a full-lookahead block and registers the group carry for the next
// stage. Skew registers carry the unprocessed upper operand bits forward, and
// deskew registers carry the finished lower sum bits forward.
// A single global advance enable (adv = !out_valid || out_ready) moves all stages
// at once. Latency is NG edges, counting the accepting edge. Throughput is one
// result per cycle.
// Optional build macro: CLA_SAT_EN enables signed saturation of sum on overflow.
// With the macro undefined, sum is the wrapped modulo-2^WIDTH result.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    // Full-lookahead group adder. The result is packed as
    // {carry into group msb, carry out of group, group sum}.
    function automatic logic [GROUP+1:0] cla_group(
        input logic [GROUP-1:0] x,
        input logic [GROUP-1:0] y,
        input logic             ci
    );
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             all_p;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci, each term formed directly
            all_p  = 1'b1;
            c[i+1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & all_p);
                all_p  = all_p & p[j];
            end
            c[i+1] = c[i+1] | (all_p & ci);
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

`ifdef CLA_SAT_EN
    // Clamp to the signed extreme matching the sign of the true result.
    // On overflow both effective operands share the sign bit, so a's msb gives that sign.
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] s,
        input logic             of,
        input logic             a_msb
    );
        if (!of)
            return s;
        else if (a_msb)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    logic             adv;
    logic [WIDTH-1:0] bx_in;
    logic             c0_in;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is A + ~B + !borrow; the remaining logic only ever adds.
    assign bx_in = sub ? ~b : b;
    assign c0_in = sub ? !cin : cin;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] bx_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [GROUP+1:0] grp;
        logic [WIDTH-1:0] s_next;

        if (k == 0) begin : g_src
            assign a_src  = a;
            assign bx_src = bx_in;
            assign s_src  = '0;
            assign c_src  = c0_in;
            assign v_src  = in_valid;
        end else begin : g_src
            assign a_src  = g_stage[k-1].g_reg.a_pipe;
            assign bx_src = g_stage[k-1].g_reg.bx_pipe;
            assign s_src  = g_stage[k-1].g_reg.s_pipe;
            assign c_src  = g_stage[k-1].g_reg.c_pipe;
            assign v_src  = g_stage[k-1].g_reg.v_pipe;
        end

        assign grp = cla_group(a_src[k*GROUP +: GROUP], bx_src[k*GROUP +: GROUP], c_src);

        // Merge this stage's group sum into the deskewed partial result.
        always_comb begin
            s_next                    = s_src;
            s_next[k*GROUP +: GROUP]  = grp[GROUP-1:0];
        end

        if (k < NG - 1) begin : g_reg
            logic             v_pipe;
            logic             c_pipe;
            logic [WIDTH-1:0] a_pipe;
            logic [WIDTH-1:0] bx_pipe;
            logic [WIDTH-1:0] s_pipe;
            logic             unused_msb_carry;

            // The carry into the group msb only matters in the last group.
            assign unused_msb_carry = grp[GROUP+1];

            // ---- stage boundary k -> k+1 ----
            // Valid bit is the only control state here; reset flushes in-flight work.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    v_pipe <= 1'b0;
                else if (adv)
                    v_pipe <= v_src;
            end

            // Data advances with the pipeline; contents of invalid stages are don't-care.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_pipe  <= a_src;
                    bx_pipe <= bx_src;
                    s_pipe  <= s_next;
                    c_pipe  <= grp[GROUP];
                end
            end
        end else begin : g_out
            logic             ovf_next;
            logic [WIDTH-1:0] sum_next;
            logic             unused_src;

            // Only the last group's operand bits are consumed here.
            assign unused_src = ^{a_src, bx_src};
            assign ovf_next   = grp[GROUP+1] ^ grp[GROUP];

`ifdef CLA_SAT_EN
            assign sum_next = saturate(s_next, ovf_next, a_src[WIDTH-1]);
`else
            assign sum_next = s_next;
`endif

            // ---- output stage ----
            // Output register: the last stage writes straight into the result ports.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (adv) begin
                    out_valid <= v_src;
                    sum       <= sum_next;
                    cout      <= grp[GROUP];
                    ovf       <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder (WIDTH=16, GROUP=4).
// Expected results are queued when operands are accepted and compared when results pop.
module tb_pipelined_cla_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    typedef struct packed {
        logic         acc;
        logic         pop;
        logic         in_rdy;
        logic         vld;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } snap_t;

    typedef struct packed {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vci;
        logic         vsub;
        logic [W-1:0] vs;
        logic         vc;
        logic         vo;
    } vec_t;

    res_t scb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain wide addition, independent of the lookahead structure.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        logic [W-1:0] bx;
        logic         c0;
        logic [W:0]   full;
        res_t         r;
        bx   = sb ? ~y : y;
        c0   = sb ? ~ci : ci;
        full = {1'b0, x} + {1'b0, bx} + {{W{1'b0}}, c0};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.o  = (x[W-1] == bx[W-1]) && (r.s[W-1] != x[W-1]);
`ifdef CLA_SAT_EN
        if (r.o)
            r.s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return r;
    endfunction

    // One clock: sample handshakes/outputs at negedge, return 1 time unit after posedge.
    task automatic step(output snap_t sn);
        @(negedge clk);
        sn.acc    = in_valid && in_ready;
        sn.pop    = out_valid && out_ready;
        sn.in_rdy = in_ready;
        sn.vld    = out_valid;
        sn.s      = sum;
        sn.c      = cout;
        sn.o      = ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t sn;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got=%b exp=0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        step(sn);
        step(sn);
        rst = 1'b0;
        step(sn);
    endtask

    task automatic test_directed();
        vec_t  vt[7];
        snap_t sn;
        res_t  e;
        int    lat;
        vt[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef CLA_SAT_EN
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
`else
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif
        vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[5] = '{16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0};
        vt[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a = vt[i].va; b = vt[i].vb; cin = vt[i].vci; sub = vt[i].vsub; in_valid = 1'b1;
            scb.push_back('{vt[i].vs, vt[i].vc, vt[i].vo});
            step(sn);
            in_valid = 1'b0;
            n_cmp++; if (sn.acc !== 1'b1) begin n_err++; $display("FAIL dir%0d_accept got=%b exp=1", i, sn.acc); end
            lat = 1;
            while (out_valid !== 1'b1 && lat < 20) begin
                step(sn);
                lat++;
            end
            e = scb.pop_front();
            n_cmp++; if (lat !== NG) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NG); end
            n_cmp++; if (sum !== e.s) begin n_err++; $display("FAIL dir%0d_sum got=%h exp=%h", i, sum, e.s); end
            n_cmp++; if (cout !== e.c) begin n_err++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, e.c); end
            n_cmp++; if (ovf !== e.o) begin n_err++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, e.o); end
            step(sn);
        end
    endtask

    task automatic test_back_to_back();
        snap_t sn;
        res_t  e;
        int    sent = 0;
        int    rcvd = 0;
        int    cyc  = 0;
        scb.delete();
        out_ready = 1'b1;
        while (rcvd < 10 && cyc < 100) begin
            in_valid = (sent < 10);
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            step(sn);
            if (sn.acc) begin scb.push_back(model(a, b, cin, sub)); sent++; end
            if (sn.pop) begin
                if (scb.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_extra_result got=%h exp=none", sn.s);
                end else begin
                    e = scb.pop_front();
                    n_cmp++;
                    if ({sn.s, sn.c, sn.o} !== {e.s, e.c, e.o}) begin
                        n_err++; $display("FAIL b2b_result%0d got=%h/%b/%b exp=%h/%b/%b", rcvd, sn.s, sn.c, sn.o, e.s, e.c, e.o);
                    end
                end
                rcvd++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++; if (cyc !== 10 + NG) begin n_err++; $display("FAIL b2b_cycles got=%0d exp=%0d", cyc, 10 + NG); end
    endtask

    task automatic test_backpressure();
        int    pat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
        snap_t sn;
        res_t  e;
        int    sent   = 0;
        int    rcvd   = 0;
        int    cyc    = 0;
        int    stalls = 0;
        scb.delete();
        while (rcvd < 8 && cyc < 200) begin
            out_ready = 1'(pat[cyc % 8]);
            in_valid  = (sent < 8);
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            step(sn);
            if (sn.acc) begin scb.push_back(model(a, b, cin, sub)); sent++; end
            if (sn.pop) begin
                if (scb.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL bp_extra_result got=%h exp=none", sn.s);
                end else begin
                    e = scb.pop_front();
                    n_cmp++;
                    if ({sn.s, sn.c, sn.o} !== {e.s, e.c, e.o}) begin
                        n_err++; $display("FAIL bp_result%0d got=%h/%b/%b exp=%h/%b/%b", rcvd, sn.s, sn.c, sn.o, e.s, e.c, e.o);
                    end
                end
                rcvd++;
            end
            if (sn.vld && !out_ready) begin
                stalls++;
                n_cmp++; if (sn.in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_stall got=%b exp=0", sn.in_rdy); end
                n_cmp++;
                if ({out_valid, sum, cout, ovf} !== {1'b1, sn.s, sn.c, sn.o}) begin
                    n_err++; $display("FAIL bp_hold got=%b/%h/%b/%b exp=1/%h/%b/%b", out_valid, sum, cout, ovf, sn.s, sn.c, sn.o);
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (rcvd !== 8) begin n_err++; $display("FAIL bp_count got=%0d exp=8", rcvd); end
        n_cmp++; if (stalls == 0) begin n_err++; $display("FAIL bp_no_stall_seen got=%0d exp=>0", stalls); end
    endtask

    task automatic test_reset_midflight();
        snap_t sn;
        res_t  e;
        int    stale = 0;
        int    lat;
        scb.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = W'(16'h0101 * (i + 1)); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            step(sn);
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid got=%b exp=1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, sum, cout, ovf} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL rstmid_async got=%b/%h/%b/%b exp=0/0000/0/0", out_valid, sum, cout, ovf);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(sn);
            if (sn.vld) stale++;
        end
        n_cmp++; if (stale !== 0) begin n_err++; $display("FAIL rstmid_stale got=%0d exp=0", stale); end
        a = 16'h4321; b = 16'h1111; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
        scb.push_back(model(a, b, cin, sub));
        step(sn);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            step(sn);
            lat++;
        end
        e = scb.pop_front();
        n_cmp++; if (lat !== NG) begin n_err++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, NG); end
        n_cmp++; if (sum !== e.s) begin n_err++; $display("FAIL rstmid_sum got=%h exp=%h", sum, e.s); end
        step(sn);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output. The operand is split into NG = WIDTH/GROUP groups. Each group is resolved by a GROUP-bit lookahead block (generate/propagate with full lookahead inside the group) in its own pipeline stage, with the carry registered between stages. It serves as the general arithmetic unit for datapaths wider than a single 4-bit lookahead block, at one result per cycle.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of GROUP.
GROUP, 4, bits resolved per stage by one lookahead block; legal range 1..8.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  operand set present.
in_ready  output  1  operands accepted when in_valid && in_ready.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (subtract).
sub  input  1  0: A+B+cin; 1: A-B-cin.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out (add); NOT borrow (subtract).
ovf  output  1  signed overflow.

Behaviour:
- Reset values: all stage valid bits 0, out_valid 0, sum 0, cout 0, ovf 0. Reset takes effect asynchronously; in-flight data is discarded and never emitted.
- Global advance enable: adv = !out_valid || out_ready. This is a single enable, with no per-stage bubble collapsing.
- in_ready = adv, and the same value is driven during reset.
- On adv, every stage register loads from its predecessor. Stage 0 loads the input, and its valid bit loads in_valid.
- When adv = 0, all registers hold, and sum/cout/ovf/out_valid stay stable.
- Operand preconditioning at acceptance:
  - Effective B: bx = sub ? ~b : b.
  - Carry-in: c0 = sub ? !cin : cin.
- Stage k (k = 0..NG-1) computes, for group k:
  - p_i = a_i ^ bx_i and g_i = a_i & bx_i.
  - Internal carries in full lookahead form from the carry registered by stage k-1 (c0 for k = 0).
  - s_i = p_i ^ c_i.
- Skew/deskew registers:
  - Unprocessed upper groups of a and bx are carried forward in skew registers.
  - Completed lower sum groups are carried forward in deskew registers.
  - The last stage outputs directly into sum/cout/ovf/out_valid.
- Latency: out_valid rises exactly NG rising edges after acceptance, provided no stall occurs. Throughput is 1 result per cycle while out_ready = 1.
- Results emerge in acceptance order, with no drop or duplication under any out_ready pattern.
- cout = carry out of bit WIDTH-1.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, valid for both add and subtract.
- Boundary conditions:
  - NG = 1 degenerates to a single registered lookahead adder with latency 1.
  - Simultaneous output pop and input push in the same cycle is legal and preserves full throughput.
  - in_valid = 0 while adv = 1 inserts a bubble (valid 0) into the pipeline.
  - Data fields of invalid stages are don't-care, but must not be X-propagated onto sum while out_valid = 1.

Optional Feature:
Macro CLA_SAT_EN.
- Defined: signed saturation at the last stage. If ovf = 1:
  - sum = 0x7FF..F when the true result is positive (MSB of a after preconditioning = 0).
  - Otherwise sum = 0x800..0.
  - ovf is still reported as 1, and cout is unchanged.
- Not defined: sum is the wrapped modulo-2^WIDTH result, and there is no saturation logic.

Test Plan:
1. Defaults (WIDTH=16, GROUP=4, latency 4): a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> sum=0x0100, cout=0, ovf=0; out_valid exactly 4 cycles after acceptance.
2. Carry ripple across all groups: a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Subtract: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
4. Backpressure: 8 back-to-back random operands, out_ready pattern 1,0,0,1,0,1,1,0... -> all 8 results in order and matching the model; in_ready = 0 and outputs stable in every cycle with out_valid=1 && out_ready=0.
5. Reset mid-flight: 3 transactions in the pipeline, assert rst between clock edges -> out_valid/sum/cout/ovf go to 0 immediately. After release, no stale result appears; the next accepted operand emerges at latency 4.
6. With CLA_SAT_EN: 0x7FFF+0x0001 -> sum=0x7FFF, ovf=1. 0x8000-0x0001 (sub) -> sum=0x8000, ovf=1. 0x1234+0x0001 -> sum=0x1235, ovf=0. Repeat cases 1-2 with WIDTH=8, GROUP=2 and WIDTH=12, GROUP=3.
